// File: rtl/int_to_float.sv
// int_to_float: sequential integer -> {sign, exp, mant} float converter, one normalising shift per clock.
// Optional macro INT_TO_FLOAT_ROUND_EN adds a round-to-nearest-even stage; without it the mantissa is truncated.
module int_to_float #(
  parameter int INT_BITS  = 32,
  parameter int BITS      = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = BITS - EXP_BITS - 1,
  parameter int EXP_BIAS  = 2**(EXP_BITS-1) - 1
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic                in_signed,
  input  logic [INT_BITS-1:0] in_int,
  output logic [BITS-1:0]     out_float,
  output logic                out_ready
);

  // state    | meaning
  // ST_READY | idle, result valid, accepts in_start
  // ST_NORM  | shift magnitude left until its MSB is set
  // ST_ROUND | round to nearest even and pack (INT_TO_FLOAT_ROUND_EN only)
  typedef enum logic [1:0] {
    ST_READY = 2'd0,
`ifdef INT_TO_FLOAT_ROUND_EN
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2
`else
    ST_NORM  = 2'd1
`endif
  } state_t;

  localparam int FRAC_W = INT_BITS + MANT_BITS;
  localparam logic [EXP_BITS-1:0] EXP_INIT = EXP_BITS'(EXP_BIAS + INT_BITS - 1);

  state_t                state_q, state_d;
  logic [INT_BITS-1:0]   mag_q, mag_d;
  logic                  sgn_q, sgn_d;
  logic [EXP_BITS-1:0]   exp_q, exp_d;
  logic [BITS-1:0]       out_float_q, out_float_d;

  logic                  start_sgn;
  logic [INT_BITS-1:0]   start_mag;
  logic [FRAC_W-1:0]     frac;
  logic [MANT_BITS-1:0]  m_trunc;

  assign start_sgn = in_signed & in_int[INT_BITS-1];
  assign start_mag = start_sgn ? (~in_int + INT_BITS'(1)) : in_int;

  // Bits below the hidden one, zero-padded so mantissa, guard and sticky always exist.
  assign frac    = {mag_q[INT_BITS-2:0], {(MANT_BITS+1){1'b0}}};
  assign m_trunc = MANT_BITS'(frac >> INT_BITS);

`ifdef INT_TO_FLOAT_ROUND_EN
  logic                  guard, sticky, round_up;
  logic [MANT_BITS:0]    m_sum;
  logic [MANT_BITS-1:0]  m_rnd;
  logic [EXP_BITS-1:0]   exp_rnd;

  assign guard    = frac[INT_BITS-1];
  assign sticky   = |frac[INT_BITS-2:0];
  assign round_up = guard & (sticky | m_trunc[0]);
  assign m_sum    = {1'b0, m_trunc} + (MANT_BITS+1)'(round_up);
  // On carry-out the low bits are already zero; only the exponent moves.
  assign m_rnd    = m_sum[MANT_BITS-1:0];
  assign exp_rnd  = exp_q + EXP_BITS'(m_sum[MANT_BITS]);
`endif

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= ST_READY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY: begin
        if (in_start && (start_mag != '0)) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (mag_q[INT_BITS-1]) begin
`ifdef INT_TO_FLOAT_ROUND_EN
          state_d = ST_ROUND;
`else
          state_d = ST_READY;
`endif
        end
      end
`ifdef INT_TO_FLOAT_ROUND_EN
      ST_ROUND: state_d = ST_READY;
`endif
      default: state_d = ST_READY;
    endcase
  end

  always_comb begin
    out_ready   = (state_q == ST_READY);
    mag_d       = mag_q;
    sgn_d       = sgn_q;
    exp_d       = exp_q;
    out_float_d = out_float_q;
    case (state_q)
      ST_READY: begin
        if (in_start) begin
          sgn_d = start_sgn;
          mag_d = start_mag;
          exp_d = EXP_INIT;
          if (start_mag == '0) begin
            out_float_d = '0;
          end
        end
      end
      ST_NORM: begin
        if (!mag_q[INT_BITS-1]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_BITS'(1);
        end else begin
`ifndef INT_TO_FLOAT_ROUND_EN
          out_float_d = {sgn_q, exp_q, m_trunc};
`endif
        end
      end
`ifdef INT_TO_FLOAT_ROUND_EN
      ST_ROUND: out_float_d = {sgn_q, exp_rnd, m_rnd};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      mag_q       <= '0;
      sgn_q       <= 1'b0;
      exp_q       <= '0;
      out_float_q <= '0;
    end else begin
      mag_q       <= mag_d;
      sgn_q       <= sgn_d;
      exp_q       <= exp_d;
      out_float_q <= out_float_d;
    end
  end

  assign out_float = out_float_q;

endmodule
